muldiv_seq: RTL

- Iterative multi-cycle multiply/divide unit with its own sequencer.
- Takes the MUL (ALUControl 3'b100) and DIV (3'b110) work off the single-cycle combinational ALU path, which is too slow in that path.
- Sits beside the alu in the multicycle datapath. The main control FSM launches an operation with start, holds in its execute state while busy is high, and writes result back on done.
- Uses one shared (WIDTH+1)-bit adder/subtractor, reused every iteration.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_seq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the sequential multiply/divide unit.
package muldiv_pkg;

  // Sequencer state encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Operation select sampled with start
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // ALUControl codes the main decoder routes to this unit
  localparam logic [2:0] ALUCTL_MUL = 3'b100;
  localparam logic [2:0] ALUCTL_DIV = 3'b110;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: shift-add multiply and unsigned restoring
// divide, one bit per cycle through a single shared (WIDTH+1)-bit adder.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc: product accumulator for MUL, partial remainder for DIV
  logic [WIDTH-1:0] acc_q, acc_d;
  // a: shifted multiplicand for MUL, dividend/quotient shift register for DIV
  logic [WIDTH-1:0] a_q, a_d;
  // b: multiplier (shifted right) for MUL, divisor for DIV
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   add_x, add_y, add_sum;
  logic             add_sub;
  logic [WIDTH:0]   rem_shift;

  // Shared adder/subtractor, subtracts via two's complement when add_sub is set
  assign add_sum = add_x + (add_sub ? ~add_y : add_y) + {{WIDTH{1'b0}}, add_sub};

  // Operand selection for the shared adder
  always_comb begin
    rem_shift = {acc_q, a_q[WIDTH-1]};
    if (state_q == S_DIV) begin
      add_x   = rem_shift;
      add_y   = {1'b0, b_q};
      add_sub = 1'b1;
    end else begin
      add_x   = {1'b0, acc_q};
      add_y   = {1'b0, a_q};
      add_sub = 1'b0;
    end
  end

  // Next-state logic for the sequencer and datapath registers
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = (op == OP_DIV) ? S_DIV : S_MUL;
          cnt_d   = CW'(WIDTH - 1);
          acc_d   = '0;
          a_d     = src_a;
          b_d     = src_b;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (state_q == S_MUL) begin
          if (b_q[0]) acc_d = add_sum[WIDTH-1:0];
          a_d = a_q << 1;
          b_d = b_q >> 1;
        end else if (!add_sum[WIDTH]) begin
          // No borrow: divisor fits, keep the difference and set the quotient bit
          acc_d = add_sum[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_shift[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = (state_q == S_MUL) ? acc_d : a_d;
          dbz_d    = (state_q == S_DIV) && (b_q == '0);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == S_MUL) || (state_q == S_DIV);
  assign done        = (state_q == S_DONE);
  assign result      = result_q;
  assign flags       = {result_q[WIDTH-1], (result_q == '0), 2'b00};
  assign div_by_zero = dbz_q;

endmodule
